// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan controller for N common-anode digits.
// It includes a scan prescaler, a dead time at the start of each slot, and PWM brightness.
// Display data is double-buffered and swapped only at frame boundaries.
module ssd_scan_controller #(
  parameter int N         = 4,
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16,
  parameter int BRIGHT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*N-1:0]      numbers,
  input  logic [N-1:0]        dp,
  input  logic [N-1:0]        blank,
  input  logic                lz_suppress,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                update,
  output logic [N-1:0]        displays,
  output logic [6:0]          segments,
  output logic                dp_out,
  output logic                frame_done
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(N);

  logic [TW-1:0]  tick_q, tick_d;
  logic [DW-1:0]  digit_q, digit_d;
  logic           pending_q, pending_d;
  logic [4*N-1:0] sh_num_q, sh_num_d;
  logic [N-1:0]   sh_dp_q, sh_dp_d;
  logic [N-1:0]   sh_blank_q, sh_blank_d;
  logic [N-1:0]   disp_q, disp_d;
  logic [6:0]     seg_q, seg_d;
  logic           dpo_q, dpo_d;
  logic           fdone_q, fdone_d;

  logic           tick_last;
  logic           frame_wrap;
  logic [N:0]     zero_run;
  logic [N-1:0]   lead_zero;
  logic [BRIGHT_W-1:0] tick_lo;
  logic [3:0]     cur_nib;
  logic           lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // Leading-zero detection: a digit is a leading zero when it and every more
  // significant digit have a zero nibble and no decimal point.
  always_comb begin
    zero_run    = '0;
    zero_run[N] = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      zero_run[N-1-k] = zero_run[N-k] & (sh_num_q[4*(N-1-k) +: 4] == 4'h0)
                        & ~sh_dp_q[N-1-k];
    end
    lead_zero    = zero_run[N-1:0];
    lead_zero[0] = 1'b0;
  end

  // Scan counters, the pending/shadow handshake, and the next registered output values.
  always_comb begin
    tick_last  = (tick_q == TW'(SCAN_DIV - 1));
    frame_wrap = tick_last && (digit_q == DW'(N - 1));

    tick_d  = tick_last ? '0 : tick_q + TW'(1);
    digit_d = digit_q;
    if (tick_last) digit_d = (digit_q == DW'(N - 1)) ? '0 : digit_q + DW'(1);

    pending_d  = pending_q | update;
    sh_num_d   = sh_num_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    // An update that arrives in the wrap cycle itself is folded into this load.
    if (frame_wrap && (pending_q || update)) begin
      sh_num_d   = numbers;
      sh_dp_d    = dp;
      sh_blank_d = blank;
      pending_d  = 1'b0;
    end

    tick_lo = BRIGHT_W'(tick_q);
    cur_nib = sh_num_q[{digit_q, 2'b00} +: 4];
    lit     = (tick_q >= TW'(BLANK_CYC)) && (tick_lo <= brightness)
              && !sh_blank_q[digit_q] && !(lz_suppress && lead_zero[digit_q]);

    disp_d  = lit ? ~(N'(1) << digit_q) : '1;
    seg_d   = lit ? seg_decode(cur_nib) : '1;
    dpo_d   = lit ? ~sh_dp_q[digit_q] : 1'b1;
    fdone_d = frame_wrap;
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q     <= '0;
      digit_q    <= '0;
      pending_q  <= 1'b0;
      sh_num_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '1;
      disp_q     <= '1;
      seg_q      <= '1;
      dpo_q      <= 1'b1;
      fdone_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      digit_q    <= digit_d;
      pending_q  <= pending_d;
      sh_num_q   <= sh_num_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
      fdone_q    <= fdone_d;
    end
  end

  assign displays   = disp_q;
  assign segments   = seg_q;
  assign dp_out     = dpo_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller.
// A cycle-level reference model pushes the expected outputs for every clock.
// A monitor on the falling edge pops each entry and compares it with the outputs.
module tb_ssd_scan_controller;

  localparam int N  = 4;
  localparam int SD = 32;
  localparam int BC = 4;
  localparam int BW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  numbers = '0;
  logic [3:0]   dp = '0;
  logic [3:0]   blank = '0;
  logic         lz = 1'b0;
  logic [3:0]   bright = 4'hF;
  logic         update = 1'b0;
  logic [3:0]   displays;
  logic [6:0]   segments;
  logic         dp_out;
  logic         frame_done;

  ssd_scan_controller #(.N(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(rst_n), .numbers(numbers), .dp(dp), .blank(blank),
    .lz_suppress(lz), .brightness(bright), .update(update),
    .displays(displays), .segments(segments), .dp_out(dp_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] disp;
    logic [6:0] seg;
    logic       dpo;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: elapsed cycles since reset and the buffered display contents.
  int unsigned t;
  logic        pend;
  logic [15:0] sh_num;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;
  logic [6:0]  dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: slot and digit are derived from elapsed time in plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    int unsigned d, tk;
    bit lit, lead;
    exp_t e;
    if (!rst_n) begin
      t = 0; pend = 0; sh_num = '0; sh_dp = '0; sh_blank = '1;
      q.delete();
    end else begin
      tk = t % SD;
      d  = (t / SD) % N;
      lead = (d != 0);
      for (int j = d; j < N; j++)
        if (sh_num[4*j +: 4] != 4'h0 || sh_dp[j]) lead = 0;
      lit = (tk >= BC) && ((tk % 16) <= bright) && !sh_blank[d] && !(lz && lead);
      e.disp = lit ? ~(4'b0001 << d) : 4'hF;
      e.seg  = lit ? dec_tab[sh_num[4*d +: 4]] : 7'h7F;
      e.dpo  = lit ? ~sh_dp[d] : 1'b1;
      e.fd   = ((t % (SD*N)) == SD*N - 1);
      q.push_back(e);
      if (update) pend = 1;
      if (e.fd && pend) begin
        sh_num = numbers; sh_dp = dp; sh_blank = blank; pend = 0;
      end
      t++;
    end
  end

  // Monitor: compares the outputs away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_displays", 32'(displays), 32'hF);
      chk("rst_segments", 32'(segments), 32'h7F);
      chk("rst_dp_out", 32'(dp_out), 32'h1);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("displays", 32'(displays), 32'(e.disp));
      chk("segments", 32'(segments), 32'(e.seg));
      chk("dp_out", 32'(dp_out), 32'(e.dpo));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    run(1);
    update = 1'b0;
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    run(1);

    // Three idle frames: the display stays dark and frame_done pulses.
    run(3 * SD * N);

    // Load 1234.
    numbers = 16'h1234; dp = '0; blank = '0; bright = 4'hF;
    pulse_update();
    run(2 * SD * N + 20);

    // Change the data mid-frame with update held high.
    run(40);
    numbers = 16'hABCD; update = 1'b1;
    run(100);
    update = 1'b0;
    run(2 * SD * N);

    // Leading-zero suppression, then a decimal point on digit 2.
    numbers = 16'h0070; lz = 1'b1; dp = '0;
    pulse_update();
    run(2 * SD * N + 10);
    dp = 4'b0100;
    pulse_update();
    run(2 * SD * N + 10);

    // Brightness extremes.
    bright = 4'h0; run(SD * N);
    bright = 4'h7; run(SD * N);
    bright = 4'hF;

    // Randomized stimulus.
    for (int i = 0; i < 30; i++) begin
      numbers = 16'($urandom);
      dp      = 4'($urandom_range(0, 15));
      blank   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      lz      = 1'($urandom_range(0, 1));
      bright  = 4'($urandom_range(0, 15));
      update  = 1'($urandom_range(0, 1));
      run($urandom_range(1, 8));
      update  = 1'b0;
      run($urandom_range(1, 250));
    end

    // Assert asynchronous reset while digit 0 is lit.
    numbers = 16'h1234; dp = '0; blank = '0; lz = 1'b0; bright = 4'hF;
    pulse_update();
    run(SD * N + 5);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (displays == 4'hE) found = 1;
    end
    chk("wait_digit0_lit", 32'(found), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_displays", 32'(displays), 32'hF);
    chk("async_segments", 32'(segments), 32'h7F);
    chk("async_dp_out", 32'(dp_out), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    run(2 * SD * N);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
